// File: rtl/matmul_arbiter_if.sv
// ---------------------------------------------------------------------------
// matmul_arbiter_if
// Bundles every non-clock/reset signal of matmul_arbiter.
//   Requester side : req_valid/req_ready/req_mtx/req_vec (job in),
//                    resp_valid/resp_ready/resp_vec/resp_err (result out)
//   MatMul side    : mm_start/mm_mtx/mm_vec (job out), mm_done/mm_vec_out (in)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus the shared MatMul)
// ---------------------------------------------------------------------------
interface matmul_arbiter_if #(
    parameter int SIZE    = 2,
    parameter int OUT_W   = 17,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ-1:0]                       req_ready;
    logic [NUM_REQ-1:0][SIZE-1:0][SIZE-1:0][7:0] req_mtx;
    logic [NUM_REQ-1:0][SIZE-1:0][7:0]        req_vec;
    logic [NUM_REQ-1:0]                       resp_valid;
    logic [NUM_REQ-1:0]                       resp_ready;
    logic [SIZE-1:0][OUT_W-1:0]               resp_vec;
    logic                                     resp_err;
    logic                                     mm_start;
    logic [SIZE-1:0][SIZE-1:0][7:0]           mm_mtx;
    logic [SIZE-1:0][7:0]                     mm_vec;
    logic                                     mm_done;
    logic [SIZE-1:0][OUT_W-1:0]               mm_vec_out;

    modport slave (
        input  req_valid, req_mtx, req_vec, resp_ready, mm_done, mm_vec_out,
        output req_ready, resp_valid, resp_vec, resp_err, mm_start, mm_mtx, mm_vec
    );

    modport master (
        output req_valid, req_mtx, req_vec, resp_ready, mm_done, mm_vec_out,
        input  req_ready, resp_valid, resp_vec, resp_err, mm_start, mm_mtx, mm_vec
    );
endinterface

// File: rtl/matmul_arbiter.sv
// ---------------------------------------------------------------------------
// matmul_arbiter
// Shares one MatMul unit between NUM_REQ requesters with round-robin
// arbitration. The winner's operands are latched, the unit is started with a
// one-cycle pulse, its result (or a watchdog timeout error) is returned on the
// winner's valid/ready response channel.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - matmul_arbiter_if.slave (requester and MatMul signals)
// ---------------------------------------------------------------------------
module matmul_arbiter #(
    parameter int SIZE    = 2,
    parameter int OUT_W   = 17,
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    matmul_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t                         state_reg, state_next;
    logic [IDX_W-1:0]               rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]               grant_reg, grant_next;
    logic [CNT_W-1:0]               cnt_reg, cnt_next;
    logic [SIZE-1:0][SIZE-1:0][7:0] mtx_reg, mtx_next;
    logic [SIZE-1:0][7:0]           vec_reg, vec_next;
    logic [SIZE-1:0][OUT_W-1:0]     resp_vec_reg, resp_vec_next;
    logic                           err_reg, err_next;

    logic                           found;
    logic [IDX_W-1:0]               win;
    int                             idx;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!found && bus.req_valid[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // Per-requester handshake bits. req_ready is gated by reset so nothing is
    // accepted while reset is held, even though the state already reads IDLE.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign bus.req_ready[gi]  = !reset && (state_reg == IDLE) && found &&
                                        (win == IDX_W'(gi));
            assign bus.resp_valid[gi] = (state_reg == RESP) && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    assign bus.mm_start = (state_reg == START);
    assign bus.mm_mtx   = mtx_reg;
    assign bus.mm_vec   = vec_reg;
    assign bus.resp_vec = resp_vec_reg;
    assign bus.resp_err = err_reg;

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_next    = grant_reg;
        cnt_next      = cnt_reg;
        mtx_next      = mtx_reg;
        vec_next      = vec_reg;
        resp_vec_next = resp_vec_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    mtx_next   = bus.req_mtx[win];
                    vec_next   = bus.req_vec[win];
                    grant_next = win;
                    state_next = START;
                end
            end
            START: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                // cnt_reg == 0 marks the first WAIT cycle, where mm_done may
                // still be the sticky done left over from the previous job.
                if ((cnt_reg != '0) && bus.mm_done) begin
                    resp_vec_next = bus.mm_vec_out;
                    err_next      = 1'b0;
                    state_next    = RESP;
                end else if ((cnt_reg + 1'b1) == CNT_W'(TIMEOUT)) begin
                    resp_vec_next = '0;
                    err_next      = 1'b1;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready[grant_reg]) begin
                    rr_ptr_next = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            cnt_reg      <= '0;
            mtx_reg      <= '0;
            vec_reg      <= '0;
            resp_vec_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_reg    <= grant_next;
            cnt_reg      <= cnt_next;
            mtx_reg      <= mtx_next;
            vec_reg      <= vec_next;
            resp_vec_reg <= resp_vec_next;
            err_reg      <= err_next;
        end
    end
endmodule

// File: tb/tb_matmul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_matmul_arbiter
// Scoreboard bench: expected results are queued when a job is accepted and
// compared when the matching response handshake occurs. Includes a MatMul
// stub with sticky done (cleared one cycle after start) and a hang mode.
// ---------------------------------------------------------------------------
module tb_matmul_arbiter;
    localparam int SIZE    = 2;
    localparam int OUT_W   = 17;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 8;
    localparam int LAT     = 2;

    typedef logic [SIZE-1:0][OUT_W-1:0]     rvec_t;
    typedef logic [SIZE-1:0][SIZE-1:0][7:0] mtx_t;
    typedef logic [SIZE-1:0][7:0]           vec_t;
    typedef struct {
        int    id;
        rvec_t vec;
        logic  err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    matmul_arbiter_if #(.SIZE(SIZE), .OUT_W(OUT_W), .NUM_REQ(NUM_REQ)) bus ();

    matmul_arbiter #(.SIZE(SIZE), .OUT_W(OUT_W), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic rvec_t matvec(input mtx_t m, input vec_t v);
        rvec_t y;
        for (int r = 0; r < SIZE; r++) begin
            y[r] = '0;
            for (int c = 0; c < SIZE; c++)
                y[r] = y[r] + OUT_W'(m[r][c]) * OUT_W'(v[c]);
        end
        return y;
    endfunction

    // MatMul stub: done is sticky and only cleared the cycle after start.
    logic hang = 1'b0;
    logic start_d;
    int   lat_cnt;
    always @(posedge clk) begin
        if (reset) begin
            start_d        <= 1'b0;
            lat_cnt        <= 0;
            bus.mm_done    <= 1'b0;
            bus.mm_vec_out <= '0;
        end else begin
            start_d <= bus.mm_start;
            if (start_d) begin
                bus.mm_done <= 1'b0;
                lat_cnt     <= hang ? 0 : LAT;
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin
                    bus.mm_done    <= 1'b1;
                    bus.mm_vec_out <= matvec(bus.mm_mtx, bus.mm_vec);
                end
            end
        end
    end

    int    n_cmp = 0;
    int    n_err = 0;
    exp_t  sb[$];
    int    acc_log[$];
    int    jobs_left[NUM_REQ];
    int    cyc = 0;
    int    start_cyc = 0;
    int    starts_seen = 0;
    int    resp1_seen = 0;
    logic  prev_start = 1'b0;
    logic  resp_prev = 1'b0;
    rvec_t last_vec;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: sample outputs, take the edge, then update drivers for
    // any job that was accepted on that edge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] hs;
        exp_t e;
        #1;
        acc = bus.req_valid & bus.req_ready;
        hs  = bus.resp_valid & bus.resp_ready;
        if (bus.mm_start) begin
            check("mm_start_consec", 64'(prev_start), 64'd0);
            start_cyc = cyc;
            starts_seen++;
        end
        if (bus.resp_valid[1]) resp1_seen++;
        if (bus.resp_valid != '0) begin
            check("req_ready_busy", 64'(bus.req_ready), 64'd0);
            if (sb.size() == 0) begin
                check("spurious_resp", 64'(bus.resp_valid), 64'd0);
            end else begin
                e = sb[0];
                check("resp_onehot", 64'(bus.resp_valid), 64'(1 << e.id));
                if (!resp_prev)
                    check("resp_latency", 64'(cyc - start_cyc), e.err ? 64'(TIMEOUT + 1) : 64'(LAT + 3));
                if (hs != '0) begin
                    check("resp_vec", 64'(bus.resp_vec), 64'(e.vec));
                    check("resp_err", 64'(bus.resp_err), 64'(e.err));
                    last_vec = bus.resp_vec;
                    $display("resp id=%0d vec=%0h err=%0b", e.id, bus.resp_vec, bus.resp_err);
                    void'(sb.pop_front());
                end
            end
        end
        prev_start = bus.mm_start;
        resp_prev  = |bus.resp_valid;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                e.id  = i;
                e.err = hang;
                e.vec = hang ? '0 : matvec(bus.req_mtx[i], bus.req_vec[i]);
                sb.push_back(e);
                acc_log.push_back(i);
                check("mm_mtx_latch", 64'(bus.mm_mtx), 64'(bus.req_mtx[i]));
                check("mm_vec_latch", 64'(bus.mm_vec), 64'(bus.req_vec[i]));
                $display("accept id=%0d mtx=%0h vec=%0h", i, bus.req_mtx[i], bus.req_vec[i]);
                jobs_left[i]--;
                if (jobs_left[i] == 0) begin
                    bus.req_valid[i] = 1'b0;
                end else begin
                    for (int r = 0; r < SIZE; r++) begin
                        bus.req_vec[i][r] = 8'($urandom);
                        for (int c = 0; c < SIZE; c++) bus.req_mtx[i][r][c] = 8'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((jobs_left[0] + jobs_left[1] + sb.size()) != 0 && n < 400) begin
            step();
            n++;
        end
        check(tag, 64'(jobs_left[0] + jobs_left[1] + sb.size()), 64'd0);
    endtask

    task automatic post(input int i, input mtx_t m, input vec_t v, input int jobs);
        bus.req_mtx[i]   = m;
        bus.req_vec[i]   = v;
        jobs_left[i]     = jobs;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        jobs_left[0] = 0;
        jobs_left[1] = 0;
        sb.delete();
        step();
        step();
        reset = 1'b0;
        resp_prev  = 1'b0;
        prev_start = 1'b0;
    endtask

    mtx_t m0, m1;
    vec_t v0, v1;
    int   base;
    int   n;

    initial begin
        m0 = '0; m1 = '0; v0 = '0; v1 = '0;
        m0[0][0] = 8'd1; m0[0][1] = 8'd2; m0[1][0] = 8'd3; m0[1][1] = 8'd4;
        v0[0] = 8'd1; v0[1] = 8'd2;
        m1[0][0] = 8'd5; m1[0][1] = 8'd6; m1[1][0] = 8'd7; m1[1][1] = 8'd8;
        v1[0] = 8'd3; v1[1] = 8'd4;
        bus.req_valid  = '0;
        bus.req_mtx    = '0;
        bus.req_vec    = '0;
        bus.resp_ready = '1;
        jobs_left[0] = 0;
        jobs_left[1] = 0;
        last_vec = '0;
        #1;
        reset = 1'b1;
        step();
        step();
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mm_start", 64'(bus.mm_start), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_vec", 64'(bus.resp_vec), 64'd0);
        check("rst_mm_mtx", 64'(bus.mm_mtx), 64'd0);
        reset = 1'b0;
        step();

        // 1: requester 0 alone
        starts_seen = 0;
        resp1_seen  = 0;
        post(0, m0, v0, 1);
        drain("t1_drain");
        check("t1_y0", 64'(last_vec[0]), 64'd5);
        check("t1_y1", 64'(last_vec[1]), 64'd11);
        check("t1_starts", 64'(starts_seen), 64'd1);
        check("t1_resp1_never", 64'(resp1_seen), 64'd0);

        // 2: both valid together after reset (rr_ptr = 0)
        apply_reset();
        base = acc_log.size();
        post(0, m0, v0, 1);
        post(1, m1, v1, 1);
        drain("t2_drain");
        check("t2_first", 64'(acc_log[base]), 64'd0);
        check("t2_second", 64'(acc_log[base + 1]), 64'd1);
        check("t2_y0", 64'(last_vec[0]), 64'd39);
        check("t2_y1", 64'(last_vec[1]), 64'd53);

        // 3: both continuously valid, six jobs
        base = acc_log.size();
        post(0, m0, v0, 3);
        post(1, m1, v1, 3);
        drain("t3_drain");
        for (int k = 0; k < 6; k++) check("t3_order", 64'(acc_log[base + k]), 64'(k % 2));

        // 4: requester 0 stalls its response for 10 cycles
        base = acc_log.size();
        bus.resp_ready[0] = 1'b0;
        post(0, m1, v0, 1);
        post(1, m0, v1, 1);
        n = 0;
        while (!bus.resp_valid[0] && n < 50) begin
            step();
            n++;
        end
        check("t4_resp_seen", 64'(bus.resp_valid[0]), 64'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("t4_hold_valid", 64'(bus.resp_valid), 64'd1);
            check("t4_hold_vec", 64'(bus.resp_vec), 64'(sb[0].vec));
            check("t4_no_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready[0] = 1'b1;
        drain("t4_drain");
        check("t4_then_req1", 64'(acc_log[base + 1]), 64'd1);

        // 5: hung MatMul, then a normal job
        hang = 1'b1;
        post(0, m0, v1, 1);
        drain("t5_drain");
        hang = 1'b0;
        post(1, m1, v0, 1);
        drain("t5_next");
        check("t5_next_y0", 64'(last_vec[0]), 64'(matvec(m1, v0)[0]));

        // 6: reset during WAIT
        post(0, m0, v0, 1);
        n = 0;
        while (!prev_start && n < 20) begin
            step();
            n++;
        end
        check("t6_started", 64'(prev_start), 64'd1);
        step();
        bus.req_valid[1] = 1'b1;
        bus.req_mtx[1]   = m1;
        bus.req_vec[1]   = v1;
        reset = 1'b1;
        #1;
        check("t6_req_ready", 64'(bus.req_ready), 64'd0);
        check("t6_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("t6_mm_start", 64'(bus.mm_start), 64'd0);
        check("t6_mm_mtx", 64'(bus.mm_mtx), 64'd0);
        check("t6_mm_vec", 64'(bus.mm_vec), 64'd0);
        check("t6_resp_vec", 64'(bus.resp_vec), 64'd0);
        sb.delete();
        bus.req_valid[0] = 1'b0;
        jobs_left[0] = 0;
        jobs_left[1] = 1;
        step();
        step();
        reset = 1'b0;
        resp_prev  = 1'b0;
        prev_start = 1'b0;
        base = acc_log.size();
        drain("t6_drain");
        check("t6_accepts", 64'(acc_log.size() - base), 64'd1);
        if (acc_log.size() > base) check("t6_grant1", 64'(acc_log[base]), 64'd1);
        for (int k = 0; k < 10; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/matmul_arbiter.md
Name: matmul_arbiter

Overview:
- Shares one MatMul unit between NUM_REQ independent requesters.
- Round-robin arbitration between requesters.
- Latches the winner's operands, pulses the unit's start, waits for done, then returns the result on a per-requester valid/ready response channel.
- Adds a watchdog timeout so a hung unit cannot stall all requesters.

Parameters:
- SIZE, 2, matrix/vector dimension; must match the shared MatMul instance.
- OUT_W, 17, result element width; must match the MatMul vec_out width.
- NUM_REQ, 2, number of requesters, >= 1.
- TIMEOUT, 64, max cycles in WAIT before an error response is issued.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  [NUM_REQ]  requester i has a job.
- req_ready  out  [NUM_REQ]  job i accepted this cycle.
- req_mtx  in  [NUM_REQ][SIZE][SIZE] x 8  matrix per requester.
- req_vec  in  [NUM_REQ][SIZE] x 8  vector per requester.
- resp_valid  out  [NUM_REQ]  result available for requester i.
- resp_ready  in  [NUM_REQ]  requester i takes the result.
- resp_vec  out  [SIZE] x OUT_W  result; shared bus, meaningful only where resp_valid is set.
- resp_err  out  1  result is a timeout error; qualified by resp_valid.
- mm_start  out  1  start pulse to MatMul.
- mm_mtx  out  [SIZE][SIZE] x 8  operand matrix to MatMul.
- mm_vec  out  [SIZE] x 8  operand vector to MatMul.
- mm_done  in  1  MatMul done; sticky until its next start.
- mm_vec_out  in  [SIZE] x OUT_W  MatMul result.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, grant=0.
  - All req_ready, resp_valid, mm_start, resp_err = 0.
  - resp_vec, mm_mtx, mm_vec = 0.
  - Timeout counter = 0.
  - Reset mid-job abandons the job; no response is ever issued for it.
- State IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set index g wins.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits = 0.
  - On that edge: latch req_mtx[g]/req_vec[g] into mm_mtx/mm_vec, grant=g, go to START.
  - No req_valid set: stay in IDLE; all req_ready = 0.
- State START:
  - mm_start=1 for exactly this one cycle.
  - Operands stay held; go to WAIT; clear the timeout counter.
- State WAIT:
  - mm_start=0; operands stay held.
  - mm_done is ignored in the first WAIT cycle, because a stale sticky done may still be high.
  - From the second WAIT cycle, mm_done=1: latch mm_vec_out into resp_vec, resp_err=0, go to RESP.
  - Timeout: counter increments each WAIT cycle. When it reaches TIMEOUT: resp_vec=0, resp_err=1, go to RESP.
- State RESP:
  - resp_valid[grant]=1; resp_vec and resp_err held stable.
  - On resp_ready[grant]=1: resp_valid drops next cycle, rr_ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
- At most one job in flight. req_ready is 0 in every state except IDLE.
- Latency: accept at edge 0, mm_start high in cycle 1, WAIT from cycle 2. If done is first seen in cycle k, resp_valid is high from cycle k+1.
- Minimum accept-to-accept spacing per job is 5 cycles.
- Requester protocol: once req_valid is asserted, the requester holds it and the operands stable until req_ready.
- Arithmetic: none; resp_vec is a straight copy of mm_vec_out, width OUT_W.

Test Plan:
1. Req0 only, mtx {{1,2},{3,4}}, vec {1,2}, resp_ready=1 -> one mm_start pulse; resp_valid[0] with resp_vec {5,11}, resp_err=0; resp_valid[1] never asserts.
2. Req0 and req1 valid in the same cycle; req1 mtx {{5,6},{7,8}}, vec {3,4} -> req0 granted first ({5,11}), then req1 ({39,53}).
3. Both requesters continuously valid for 6 jobs -> grant order 0,1,0,1,0,1; mm_start is never high on two consecutive cycles.
4. resp_ready[0]=0 for 10 cycles -> resp_valid[0] and resp_vec held stable; req_ready stays 0 despite req1 valid; req1 granted after resp_ready[0] rises.
5. MatMul stub holding mm_done=0 with TIMEOUT=8 -> resp_valid with resp_err=1 and resp_vec {0,0}, 8 WAIT cycles after START; next job proceeds normally.
6. Assert reset during WAIT -> all outputs zero immediately with no response for that job; after release, req1 alone is granted (rr_ptr=0, search wraps to 1).
